// File: rtl/sensor_sampler.sv
// ============================================================================
// sensor_sampler: sync + debounce of raw sensor bus, valid/ready publisher.
// Optional macro SENSOR_SAMPLE_COUNT_EN adds an 8-bit handshake counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module sensor_sampler #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sensor_raw,
   output logic [WIDTH-1:0] sample_data,
   output logic             sample_valid,
   input  logic             sample_ready,
   output logic             overrun
`ifdef SENSOR_SAMPLE_COUNT_EN
   ,
   output logic [7:0]       sample_count
`endif
);

   localparam logic [0:0]       c_st_idle  = 1'b0;
   localparam logic [0:0]       c_st_valid = 1'b1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_fire = CNT_W'(DEBOUNCE_CYCLES - 2);

   logic [WIDTH-1:0] r_sync1, r_sync2, r_cand, r_stable, r_pend, r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pend_v, r_overrun;
   logic [0:0]       r_state, w_state_nxt;
   logic             w_event, w_hs, w_valid;

   // Event fires on the edge where the counter reaches its saturation value.
   assign w_event = (r_sync2 == r_cand) && (r_cnt == c_cnt_fire) && (r_cand != r_stable);
   assign w_hs    = w_valid & sample_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_cand   <= '0;
         r_cnt    <= '0;
         r_stable <= '0;
      end else begin
         r_sync1 <= sensor_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
         end else if (r_cnt < c_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_event)
            r_stable <= r_cand;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= c_st_idle;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_event) w_state_nxt = c_st_valid;
         c_st_valid: if (w_hs && !w_event && !r_pend_v) w_state_nxt = c_st_idle;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_valid = (r_state == c_st_valid);
   end

   // A coinciding event supersedes any pending value, since cand is newer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_pend    <= '0;
         r_pend_v  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_state == c_st_idle) begin
            if (w_event)
               r_data <= r_cand;
         end else if (w_hs) begin
            if (w_event)
               r_data <= r_cand;
            else if (r_pend_v)
               r_data <= r_pend;
            r_pend_v <= 1'b0;
         end else if (w_event) begin
            r_pend    <= r_cand;
            r_pend_v  <= 1'b1;
            r_overrun <= r_pend_v;
         end
      end
   end

   assign sample_data  = r_data;
   assign sample_valid = w_valid;
   assign overrun      = r_overrun;

`ifdef SENSOR_SAMPLE_COUNT_EN
   logic [7:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_count <= '0;
      else if (w_hs)
         r_count <= r_count + 8'd1;
   end

   assign sample_count = r_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sensor_sampler.sv
// ============================================================================
// tb_sensor_sampler: directed self-checking bench for sensor_sampler.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sensor_sampler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] sensor_raw = 4'd0;
   logic [3:0] sample_data;
   logic       sample_valid;
   logic       sample_ready = 1'b0;
   logic       overrun;
`ifdef SENSOR_SAMPLE_COUNT_EN
   logic [7:0] sample_count;
`endif

   int n_cmp = 0;
   int n_err = 0;
   int ov_sum;

   sensor_sampler dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sensor_raw   (sensor_raw),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
`ifdef SENSOR_SAMPLE_COUNT_EN
      ,
      .sample_count (sample_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!sample_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {31'd0, sample_valid}, 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_data", {28'd0, sample_data}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      rst_n = 1'b1;

      // 1: stable 1001 with ready high, valid at edge 10, then one handshake
      sensor_raw   = 4'b1001;
      sample_ready = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         chk($sformatf("t1_novalid_e%0d", e), {31'd0, sample_valid}, 32'd0);
      end
      tick();
      chk("t1_valid_e10", {31'd0, sample_valid}, 32'd1);
      chk("t1_data_e10", {28'd0, sample_data}, 32'd9);
      tick();
      chk("t1_idle_after_hs", {31'd0, sample_valid}, 32'd0);

      // 2: glitch back to the published value
      sensor_raw = 4'b0110;
      repeat (3) tick();
      sensor_raw = 4'b1001;
      for (int e = 0; e < 20; e++) begin
         tick();
         chk("t2_no_valid", {31'd0, sample_valid}, 32'd0);
         chk("t2_no_overrun", {31'd0, overrun}, 32'd0);
      end

      // 3: ready low, 3 then 7 then 15; one overrun, then 3 and 15 back-to-back
      sample_ready = 1'b0;
      sensor_raw   = 4'b0011;
      repeat (12) tick();
      chk("t3_valid3", {31'd0, sample_valid}, 32'd1);
      chk("t3_data3", {28'd0, sample_data}, 32'd3);
      sensor_raw = 4'b0111;
      ov_sum = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         ov_sum += int'(overrun);
      end
      chk("t3_no_overrun_on7", ov_sum, 0);
      chk("t3_data_held_3a", {28'd0, sample_data}, 32'd3);
      sensor_raw = 4'b1111;
      ov_sum = 0;
      for (int e = 0; e < 12; e++) begin
         tick();
         ov_sum += int'(overrun);
      end
      chk("t3_one_overrun", ov_sum, 1);
      chk("t3_data_held_3b", {28'd0, sample_data}, 32'd3);
      chk("t3_valid_held", {31'd0, sample_valid}, 32'd1);
      sample_ready = 1'b1;
      tick();
      chk("t3_b2b_valid", {31'd0, sample_valid}, 32'd1);
      chk("t3_b2b_data15", {28'd0, sample_data}, 32'd15);
      tick();
      chk("t3_idle", {31'd0, sample_valid}, 32'd0);

      // 4: event for 12 coincides with a handshake of 5
      sample_ready = 1'b0;
      sensor_raw   = 4'd5;
      repeat (12) tick();
      chk("t4_data5", {28'd0, sample_data}, 32'd5);
      sensor_raw = 4'd12;
      repeat (9) tick();
      chk("t4_still5", {28'd0, sample_data}, 32'd5);
      sample_ready = 1'b1;
      tick();
      chk("t4_data12", {28'd0, sample_data}, 32'd12);
      chk("t4_valid_held", {31'd0, sample_valid}, 32'd1);
      chk("t4_no_overrun", {31'd0, overrun}, 32'd0);
      tick();
      chk("t4_idle", {31'd0, sample_valid}, 32'd0);

      // 5: asynchronous reset mid-VALID, then a fresh debounce interval
      sample_ready = 1'b0;
      sensor_raw   = 4'd3;
      repeat (12) tick();
      chk("t5_valid_before", {31'd0, sample_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_valid", {31'd0, sample_valid}, 32'd0);
      chk("t5_async_data", {28'd0, sample_data}, 32'd0);
      sensor_raw = 4'b1010;
      #1;
      rst_n = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         chk($sformatf("t5_novalid_e%0d", e), {31'd0, sample_valid}, 32'd0);
      end
      tick();
      chk("t5_valid_e10", {31'd0, sample_valid}, 32'd1);
      chk("t5_data_e10", {28'd0, sample_data}, 32'd10);

`ifdef SENSOR_SAMPLE_COUNT_EN
      // 6: 257 handshakes wrap the counter to 1
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      chk("t6_count_rst", {24'd0, sample_count}, 32'd0);
      sample_ready = 1'b1;
      for (int i = 0; i < 257; i++) begin
         sensor_raw = (i % 2 == 1) ? 4'd1 : 4'd2;
         wait_valid($sformatf("t6_valid_%0d", i));
         tick();
      end
      chk("t6_count_wrap", {24'd0, sample_count}, 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
